// File: rtl/aes_link_scheduler.sv
// Round-robin scheduler for two AES requesters sharing one serial link: shifts {msg,key} out, waits for done, shifts the result in.
// Result returns 2*32*nb+32*nk+2 cycles after accept when done is already up; the response is held until rsp_ready and blocks new grants.
module aes_link_scheduler #(
  parameter int nk          = 8,
  parameter int nb          = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [32*nb-1:0]  req0_msg,
  input  logic [32*nk-1:0]  req0_key,
  input  logic              req0_mode,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [32*nb-1:0]  req1_msg,
  input  logic [32*nk-1:0]  req1_key,
  input  logic              req1_mode,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [32*nb-1:0]  rsp_data,
  output logic              rsp_id,
  output logic              rsp_err,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_enc,
  output logic              cs_dec,
  input  logic              data_done_1,
  input  logic              data_done_2,
  output logic              busy
);

  localparam int MW   = 32 * nb;
  localparam int KW   = 32 * nk;
  localparam int SW   = MW + KW;
  localparam int CMAX = (SW > TIMEOUT_CYC) ? SW : TIMEOUT_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SEND_LAST = CW'(SW - 1);
  localparam logic [CW-1:0] RECV_LAST = CW'(MW - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, RESP} state_t;

  state_t          r_state;
  logic [SW-1:0]   r_shift;
  logic [MW-1:0]   r_result;
  logic [CW-1:0]   r_cnt;
  logic            r_mode;
  logic            r_id;
  logic            r_ptr;

  logic            w_idle;
  logic            w_grant0;
  logic            w_grant1;
  logic            w_done;
  logic [MW-1:0]   w_result_nxt;

  // Readies are gated by rst so nothing is accepted while reset is held.
  assign w_idle       = rst & (r_state == IDLE);
  assign w_grant0     = w_idle & req0_valid & (~r_ptr | ~req1_valid);
  assign w_grant1     = w_idle & req1_valid & (r_ptr | ~req0_valid);
  assign req0_ready   = w_grant0;
  assign req1_ready   = w_grant1;
  assign w_done       = r_mode ? data_done_2 : data_done_1;
  assign w_result_nxt = {r_result[MW-2:0], miso};

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_mode    <= 1'b0;
      r_id      <= 1'b0;
      r_ptr     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      mosi      <= 1'b0;
      cs_enc    <= 1'b1;
      cs_dec    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant0 | w_grant1) begin
            r_state <= SEND;
            busy    <= 1'b1;
            r_cnt   <= '0;
            r_id    <= w_grant1;
            // The first bit goes out on the accept edge so SEND is exactly SW cycles.
            if (w_grant1) begin
              r_shift <= {req1_msg, req1_key};
              r_mode  <= req1_mode;
              mosi    <= req1_msg[MW-1];
              cs_enc  <= req1_mode;
              cs_dec  <= ~req1_mode;
            end else begin
              r_shift <= {req0_msg, req0_key};
              r_mode  <= req0_mode;
              mosi    <= req0_msg[MW-1];
              cs_enc  <= req0_mode;
              cs_dec  <= ~req0_mode;
            end
          end
        end
        SEND: begin
          r_shift <= r_shift << 1;
          if (r_cnt == SEND_LAST) begin
            r_state <= WAIT;
            r_cnt   <= '0;
            mosi    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            mosi  <= r_shift[SW-2];
          end
        end
        WAIT: begin
          if (w_done) begin
            r_state  <= RECV;
            r_cnt    <= '0;
            r_result <= '0;
          end else if (r_cnt == WAIT_LAST) begin
            r_state   <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_id    <= r_id;
            cs_enc    <= 1'b1;
            cs_dec    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RECV: begin
          // Done must stay up for the whole readout; a drop means the subnode gave up.
          if (!w_done) begin
            r_state   <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_id    <= r_id;
            cs_enc    <= 1'b1;
            cs_dec    <= 1'b1;
          end else begin
            r_result <= w_result_nxt;
            if (r_cnt == RECV_LAST) begin
              r_state   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_data  <= w_result_nxt;
              rsp_id    <= r_id;
              cs_enc    <= 1'b1;
              cs_dec    <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_ptr     <= ~rsp_id;
            r_state   <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_link_scheduler.sv
// Scoreboard bench for aes_link_scheduler: a subnode model drives done/miso, expected responses are queued per job.
module tb_aes_link_scheduler;

  localparam int MW = 128;
  localparam int KW = 256;
  localparam int TO = 16;

  localparam logic [127:0] MSG_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RES_A = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] MSG_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEY_B = 256'h2b7e151628aed2a6abf7158809cf4f3c762e7160f38b4da56a784d9045190cfe;
  localparam logic [127:0] RES_B = 128'h3925841d02dc09fbdc118597196a0b32;

  logic          in_clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req0_mode;
  logic [127:0]  req0_msg;
  logic [255:0]  req0_key;
  logic          req1_valid, req1_ready, req1_mode;
  logic [127:0]  req1_msg;
  logic [255:0]  req1_key;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [127:0]  rsp_data;
  logic          mosi, miso, cs_enc, cs_dec, data_done_1, data_done_2, busy;

  typedef struct {
    logic [127:0] data;
    logic         id;
    logic         err;
  } rsp_t;

  rsp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  bit   tog = 1'b0;

  aes_link_scheduler #(.nk(8), .nb(4), .TIMEOUT_CYC(TO)) dut (
    .in_clk(in_clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_msg(req0_msg), .req0_key(req0_key), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_msg(req1_msg), .req1_key(req1_key), .req1_mode(req1_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .mosi(mosi), .miso(miso), .cs_enc(cs_enc), .cs_dec(cs_dec),
    .data_done_1(data_done_1), .data_done_2(data_done_2), .busy(busy)
  );

  always #5 in_clk = ~in_clk;
  always @(posedge in_clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge in_clk);
    if (tog) data_done_1 = ~data_done_1;
  endtask

  task automatic wait_grant(input logic exp_id);
    int t;
    t = 0;
    #1;
    while (!(req0_ready || req1_ready) && t < 50) begin
      step();
      #1;
      t++;
    end
    check("grant_seen", req0_ready | req1_ready, 1'b1);
    check("one_ready", req0_ready & req1_ready, 1'b0);
    check("grant_id", req1_ready, exp_id);
    accept_cyc = cyc;
  endtask

  task automatic run_job(input logic mode, input logic id, input logic [127:0] msg, input logic [255:0] key,
                         input logic [127:0] resp, input int dly, input int drop_after,
                         input bit no_done, input bit keep);
    rsp_t        e;
    logic [383:0] s;
    logic [1:0]   sel;
    logic         csbad;
    e.err  = no_done || (drop_after > 0);
    e.data = e.err ? 128'h0 : resp;
    e.id   = id;
    sb.push_back(e);
    sel = mode ? 2'b10 : 2'b01;
    step();
    if (!keep) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_msg   = {$urandom, $urandom, $urandom, $urandom};
      req1_msg   = {$urandom, $urandom, $urandom, $urandom};
      req0_mode  = ~req0_mode;
      req1_mode  = ~req1_mode;
    end
    check("busy_send", busy, 1'b1);
    s = '0;
    csbad = 1'b0;
    for (int i = 0; i < MW + KW; i++) begin
      if (i > 0) step();
      s = {s[382:0], mosi};
      if ({cs_enc, cs_dec} != sel) csbad = 1'b1;
    end
    check("mosi_stream", s, {msg, key});
    check("cs_send", csbad, 1'b0);
    step();
    check("mosi_wait", mosi, 1'b0);
    check("cs_wait", {cs_enc, cs_dec}, sel);
    if (no_done) return;
    for (int i = 1; i < dly; i++) step();
    if (mode) data_done_2 = 1'b1;
    else data_done_1 = 1'b1;
    step();
    for (int j = 0; j < MW; j++) begin
      if (drop_after > 0 && j == drop_after) break;
      miso = resp[MW-1-j];
      step();
    end
    if (mode) data_done_2 = 1'b0;
    else data_done_1 = 1'b0;
    miso = 1'b0;
  endtask

  task automatic collect_rsp(input int exp_lat, input int hold);
    rsp_t e;
    int   t;
    logic bad;
    t = 0;
    while (!rsp_valid && t < 700) begin
      step();
      t++;
    end
    check("rsp_seen", rsp_valid, 1'b1);
    check("latency", cyc - accept_cyc, exp_lat);
    check("cs_resp", {cs_enc, cs_dec}, 2'b11);
    if (sb.size() == 0) begin
      check("sb_nonempty", 1'b0, 1'b1);
    end else begin
      e = sb.pop_front();
      check("rsp_data", rsp_data, e.data);
      check("rsp_id", rsp_id, e.id);
      check("rsp_err", rsp_err, e.err);
      bad = 1'b0;
      for (int h = 0; h < hold; h++) begin
        step();
        #1;
        if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_id !== e.id || rsp_err !== e.err
            || req0_ready || req1_ready) bad = 1'b1;
      end
      if (hold > 0) check("rsp_hold", bad, 1'b0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_clear", {rsp_valid, busy}, 2'b00);
  endtask

  initial begin
    rst = 1'b0;
    rsp_ready = 1'b0;
    req0_key = '0; req1_key = '0;
    // Reset holds with random inputs toggling.
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      req0_mode = 1'($urandom); req1_mode = 1'($urandom);
      req0_msg = {$urandom, $urandom, $urandom, $urandom};
      req1_msg = {$urandom, $urandom, $urandom, $urandom};
      miso = 1'($urandom); data_done_1 = 1'($urandom); data_done_2 = 1'($urandom);
      rsp_ready = 1'($urandom);
      step();
      #1;
      check("rst_ctl", {cs_enc, cs_dec, mosi, rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_err}, 9'b110000000);
      check("rst_data", rsp_data, 128'h0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; miso = 1'b0;
    data_done_1 = 1'b0; data_done_2 = 1'b0; rsp_ready = 1'b0;
    step();
    rst = 1'b1;
    step();

    // Encrypt via requester 0, done 8 cycles into WAIT.
    req0_msg = MSG_A; req0_key = KEY_A; req0_mode = 1'b0; req0_valid = 1'b1;
    wait_grant(1'b0);
    run_job(1'b0, 1'b0, MSG_A, KEY_A, RES_A, 8, 0, 1'b0, 1'b0);
    collect_rsp(513 + 8, 0);

    // Decrypt via requester 1 while data_done_1 toggles.
    tog = 1'b1;
    req1_msg = MSG_B; req1_key = KEY_B; req1_mode = 1'b1; req1_valid = 1'b1;
    wait_grant(1'b1);
    run_job(1'b1, 1'b1, MSG_B, KEY_B, RES_B, 3, 0, 1'b0, 1'b0);
    collect_rsp(513 + 3, 0);
    tog = 1'b0;
    data_done_1 = 1'b0;

    // Timeout with done never asserted.
    req0_msg = MSG_B; req0_key = KEY_A; req0_mode = 1'b0; req0_valid = 1'b1;
    wait_grant(1'b0);
    run_job(1'b0, 1'b0, MSG_B, KEY_A, RES_A, 1, 0, 1'b1, 1'b0);
    collect_rsp(385 + TO, 0);

    // Done dropped after 50 received bits.
    req1_msg = MSG_A; req1_key = KEY_B; req1_mode = 1'b0; req1_valid = 1'b1;
    wait_grant(1'b1);
    run_job(1'b0, 1'b1, MSG_A, KEY_B, RES_A, 2, 50, 1'b0, 1'b0);
    collect_rsp(386 + 2 + 50, 0);

    // Backpressure: rsp_ready held low for 5 cycles.
    req0_msg = MSG_A; req0_key = KEY_A; req0_mode = 1'b1; req0_valid = 1'b1;
    wait_grant(1'b0);
    run_job(1'b1, 1'b0, MSG_A, KEY_A, RES_B, 1, 0, 1'b0, 1'b0);
    collect_rsp(514, 5);

    // Reset pulled mid-SEND, then a fresh job must restart from the message MSB.
    req0_msg = MSG_B; req0_key = KEY_B; req0_mode = 1'b0; req0_valid = 1'b1;
    wait_grant(1'b0);
    step();
    req0_valid = 1'b0;
    for (int i = 1; i < 100; i++) step();
    rst = 1'b0;
    #1;
    check("rst_async", {cs_enc, cs_dec, mosi, rsp_valid, busy}, 5'b11000);
    step();
    step();
    rst = 1'b1;
    step();
    check("rst_norsp", {rsp_valid, busy}, 2'b00);
    req0_valid = 1'b1;
    wait_grant(1'b0);
    run_job(1'b0, 1'b0, MSG_B, KEY_B, RES_B, 2, 0, 1'b0, 1'b0);
    collect_rsp(515, 0);

    // Arbitration: both requesters valid from reset release onward.
    rst = 1'b0;
    step();
    req0_msg = MSG_A; req0_key = KEY_A; req0_mode = 1'b0; req0_valid = 1'b1;
    req1_msg = MSG_B; req1_key = KEY_B; req1_mode = 1'b0; req1_valid = 1'b1;
    rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_grant(1'(g % 2));
      if (g % 2 == 0) run_job(1'b0, 1'b0, MSG_A, KEY_A, RES_A, 1, 0, 1'b0, 1'b1);
      else run_job(1'b0, 1'b1, MSG_B, KEY_B, RES_B, 1, 0, 1'b0, 1'b1);
      collect_rsp(514, 2);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_link_scheduler.md
Name: aes_link_scheduler

Overview:
Sequencer and arbiter for the serial AES link to the encrypt and decrypt subnodes. It accepts jobs (message, key, mode) from two requesters and grants them round-robin. For each job it drives chip select and MOSI to shift out {msg,key}, waits for the selected subnode's data_done, shifts the result in from MISO, and returns it on a valid/ready response port. It replaces ad-hoc sequencing of the link with a single synchronous FSM in the in_clk domain.

Parameters:
nk, 8, key length in 32-bit words (key width 32*nk)
nb, 4, block length in 32-bit words (msg/result width 32*nb)
TIMEOUT_CYC, 4096, maximum cycles spent in WAIT before the job is aborted

Ports:
in_clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has a job
req0_ready  out  1  requester 0 job accepted this cycle
req0_msg  in  32*nb  requester 0 plaintext/ciphertext
req0_key  in  32*nk  requester 0 key
req0_mode  in  1  0 = encrypt, 1 = decrypt
req1_valid, req1_ready, req1_msg, req1_key, req1_mode  same as requester 0, for requester 1
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  32*nb  result block
rsp_id  out  1  requester index of the job
rsp_err  out  1  job aborted (timeout or done dropped early)
mosi  out  1  serial data to subnode
miso  in  1  serial data from subnode
cs_enc  out  1  encrypt subnode chip select, active-low
cs_dec  out  1  decrypt subnode chip select, active-low
data_done_1  in  1  encrypt subnode result-ready level
data_done_2  in  1  decrypt subnode result-ready level
busy  out  1  high when state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, mosi=0, cs_enc=1, cs_dec=1, busy=0, counters 0, RR pointer favours requester 0.
- A reset mid-job drops the job, produces no response, and restarts from IDLE.
- States: IDLE, SEND, WAIT, RECV, RESP.
- IDLE: reqN_ready is combinational and asserted only in IDLE.
  - req0_ready = req0_valid & (ptr==0 | !req1_valid); req1_ready is symmetric. Exactly one ready at a time.
  - On valid&ready, capture the shift register {msg,key}, mode and id; go to SEND.
  - Requesters hold valid and data stable until ready. Mode and data changes after acceptance are ignored.
- SEND: lasts 32*nb+32*nk cycles (384 with defaults).
  - The CS for the captured mode is 0; the other CS stays 1.
  - mosi = current MSB of the shift register, shifting left each cycle. The message goes first, MSB first, then the key, MSB first.
  - After the last bit, go to WAIT. mosi returns to 0 outside SEND.
- WAIT: CS stays low. done = mode ? data_done_2 : data_done_1; the non-selected done input is ignored.
  - If done=1 at a clock edge, go to RECV and clear the bit counter.
  - If WAIT has lasted TIMEOUT_CYC cycles, go to RESP with rsp_err=1 and rsp_data=0.
- RECV: on each of 32*nb edges, result <= {result[32*nb-2:0], miso}. The result is received MSB first, and the first bit is sampled at the first edge in RECV.
  - If done=0 on any RECV edge, abort to RESP with rsp_err=1 and rsp_data=0.
  - After the last bit, go to RESP with rsp_err=0.
- RESP: cs_enc=cs_dec=1 and rsp_valid=1. rsp_data, rsp_id and rsp_err are held stable while rsp_valid & !rsp_ready.
  - On rsp_valid & rsp_ready, clear rsp_valid, set ptr = ~rsp_id, and go to IDLE.
  - rsp_valid is high for at least one cycle. No new grant occurs before the response is accepted.
- Latency (defaults): with the accept edge at cycle A, SEND covers A+1..A+384 and WAIT is entered at A+385. With done high at the first WAIT edge, RECV covers A+386..A+513 and rsp_valid rises at A+514.
- Counters are sized for max(32*nb+32*nk, TIMEOUT_CYC) and never wrap within a state.

Test Plan:
1. Reset: hold rst=0 with random inputs -> cs_enc=cs_dec=1, mosi=0, rsp_valid=0, busy=0, both readys 0.
2. Encrypt via req0: msg=0x00112233445566778899aabbccddeeff, key=0x000102…1f, mode=0; subnode model asserts data_done_1 8 cycles into WAIT and drives miso=0x8ea2b7ca516745bfeafc49904b496089 -> mosi sequence equals msg‖key MSB first over 384 cycles, cs_enc low, cs_dec=1, rsp_data equals the driven value, rsp_id=0, rsp_err=0.
3. Decrypt via req1 (mode=1): toggle data_done_1 throughout -> cs_dec low, cs_enc=1, only data_done_2 advances the FSM, and the result is returned with rsp_id=1.
4. Arbitration: both valid at the same cycle after reset, continuously -> grants in order req0, req1, req0, req1. Only one ready is high at a time, and no grant occurs while rsp_valid is pending.
5. Timeout with TIMEOUT_CYC=16 and done never asserted -> rsp_valid after 16 WAIT cycles with rsp_err=1, rsp_data=0, and both CS high. Separately, drop done after 50 RECV bits -> rsp_err=1.
6. Backpressure and reset: hold rsp_ready=0 for 5 cycles -> outputs stay stable. Pull rst low at SEND bit 100 -> immediate reset values, no response, and the next job's mosi starts again from msg MSB.
